cam_client_ctrl: RTL and testbench
==================================

Name: cam_client_ctrl

Overview:
- Initiator/controller for the 16-entry, 8-bit-key Content_Addressable_Memory responder.
- Accepts LOOKUP and INSERT requests from upstream on a valid/ready handshake.
- Sequences CAM read/write cycles, keeps a per-entry valid bitmap, allocates free slots, suppresses duplicate inserts, and returns one response per request.
- Sits between request-generating logic and the CAM instance.

Parameters:
- KEY_W, 8, key width; matches CAM din.
- ADDR_W, 4, CAM index width; matches CAM addr/dout.
- DEPTH, 16, number of CAM entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  1  0 = LOOKUP, 1 = INSERT.
- req_key  in  KEY_W  key to search or insert.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_hit  out  1  key found (LOOKUP) or already present (INSERT).
- rsp_addr  out  ADDR_W  matching index, or newly written index.
- rsp_err  out  1  INSERT refused because the table is full.
- count  out  ADDR_W+1  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- cam_wen  out  1  CAM write enable.
- cam_ren  out  1  CAM read (search) enable.
- cam_din  out  KEY_W  CAM key / write data.
- cam_addr  out  ADDR_W  CAM write index.
- cam_dout  in  ADDR_W  CAM match index.
- cam_hit  in  1  CAM match flag.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high. While `rst` is high:
  - state = IDLE, valid bitmap = 0, count = 0.
  - All outputs are 0, except req_ready = 1 after release.
- CAM contract:
  - Search and write are registered on the rising edge.
  - cam_dout/cam_hit are valid in the cycle after the cam_ren cycle.
  - On multiple matches, the CAM reports the highest matching index.
  - cam_ren has priority over cam_wen; the controller never asserts both in the same cycle.
- Allocation:
  - Next free index = DEPTH-1-count. The first insert goes to 15, the second to 14, and so on.
  - Valid entries therefore always occupy the top contiguous region.
  - Consequence: if any valid entry matches, the CAM's highest match is valid. This holds even when stale or unwritten data remains in lower entries.
  - A CAM hit at an index whose valid bit = 0 is treated as a miss.
- FSM states: IDLE, SEARCH, CHECK, WRITE, RESP.
  - IDLE: req_ready = 1. On req_valid, latch op/key and go to SEARCH.
  - SEARCH: cam_ren = 1, cam_din = key. Go to CHECK.
  - CHECK: qualified hit = cam_hit && valid[cam_dout].
    - LOOKUP: rsp_hit = qualified hit; rsp_addr = cam_dout if hit, else 0. Go to RESP.
    - INSERT with hit: rsp_hit = 1, rsp_addr = cam_dout, no write. Go to RESP.
    - INSERT, miss, full: rsp_err = 1, rsp_addr = 0. Go to RESP.
    - INSERT, miss, not full: go to WRITE.
  - WRITE: cam_wen = 1, cam_addr = DEPTH-1-count, cam_din = key. Set the valid bit, count++, rsp_addr = the written index, rsp_hit = 0. Go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle. rsp_* are registered and hold until the next response. Go to IDLE.
- Latency, counted from the accept edge:
  - LOOKUP, duplicate INSERT, or full INSERT: rsp_valid asserts 3 cycles later.
  - Fresh INSERT: rsp_valid asserts 4 cycles later.
  - Throughput: one request per 4 or 5 cycles. req_ready is 0 outside IDLE.
- Other rules:
  - req_key and req_op are ignored unless accepted. Upstream may change them freely when req_ready = 0.
  - count saturates at DEPTH, and full asserts at 16.
  - Reset mid-operation aborts with no response. Any partially issued CAM write has already landed, but the entry stays masked invalid.

Optional Feature:
- Macro CAM_STATS_EN.
- When defined, the block adds two output ports:
  - lookup_hits (8 bits): increments in RESP for each LOOKUP with rsp_hit = 1.
  - lookup_misses (8 bits): increments in RESP for each LOOKUP with rsp_hit = 0.
- Both counters saturate at 255 and reset to 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, INSERT keys 4, 8, 35 -> rsp_addr 15, 14, 13; rsp_hit = 0; count = 3; each rsp_valid arrives 4 cycles after accept.
- LOOKUP 8 -> rsp_hit = 1, rsp_addr = 14, 3-cycle latency. LOOKUP 87 -> rsp_hit = 0, rsp_addr = 0.
- INSERT 4 again (duplicate) -> rsp_hit = 1, rsp_addr = 15, cam_wen never asserts, count stays 3.
- Fill the table with 16 distinct keys 0..15 -> full = 1, count = 16. Then INSERT 200 -> rsp_err = 1, no write. Then LOOKUP 0 -> hit, rsp_addr = 15.
- Pre-load the CAM model at index 3 with key 77 (valid bit clear), then LOOKUP 77 -> rsp_hit = 0. Hold req_valid high continuously -> req_ready pulses only in IDLE and responses are never dropped.
- Assert rst during WRITE of key 100 -> no rsp_valid, count = 0. Then LOOKUP 100 -> miss. Then INSERT 100 -> rsp_addr = 15.
- With CAM_STATS_EN defined: 2 hits and 1 miss -> lookup_hits = 2, lookup_misses = 1.

Source files
------------

// File: rtl/cam_client_ctrl.sv
// cam_client_ctrl: sequences LOOKUP/INSERT requests onto a 16-entry CAM, tracking valid entries with top-down allocation.
// Define CAM_STATS_EN to add saturating lookup_hits/lookup_misses counters.
module cam_client_ctrl #(
  parameter int KEY_W  = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [KEY_W-1:0]  req_key,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              cam_wen,
  output logic              cam_ren,
  output logic [KEY_W-1:0]  cam_din,
  output logic [ADDR_W-1:0] cam_addr,
  input  logic [ADDR_W-1:0] cam_dout,
  input  logic              cam_hit
`ifdef CAM_STATS_EN
  ,
  output logic [7:0]        lookup_hits,
  output logic [7:0]        lookup_misses
`endif
);

  typedef enum logic [2:0] {IDLE, SEARCH, CHECK, WRITE, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic                rsp_err_q, rsp_err_d;

  logic                is_full;
  logic                qual_hit;
  logic [ADDR_W-1:0]   free_idx;

  assign is_full  = (count_q == DEPTH_C);
  // Valid entries fill from the top down, so a CAM hit on a clear valid bit is stale data.
  assign qual_hit = cam_hit && valid_q[cam_dout];
  assign free_idx = ADDR_W'(DEPTH - 1) - count_q[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      key_q      <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_addr_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    key_d      = key_q;
    valid_d    = valid_q;
    count_d    = count_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_addr_d = rsp_addr_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          key_d   = req_key;
          state_d = SEARCH;
        end
      end
      SEARCH: state_d = CHECK;
      CHECK: begin
        if (!op_q) begin
          rsp_hit_d  = qual_hit;
          rsp_addr_d = qual_hit ? cam_dout : '0;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (qual_hit) begin
          rsp_hit_d  = 1'b1;
          rsp_addr_d = cam_dout;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (is_full) begin
          rsp_hit_d  = 1'b0;
          rsp_addr_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (!is_full) begin
          valid_d[free_idx] = 1'b1;
          count_d           = count_q + (ADDR_W+1)'(1);
        end
        rsp_hit_d  = 1'b0;
        rsp_addr_d = free_idx;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_hit   = rsp_hit_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;
  assign full      = is_full;
  assign cam_ren   = (state_q == SEARCH);
  assign cam_wen   = (state_q == WRITE);
  assign cam_din   = ((state_q == SEARCH) || (state_q == WRITE)) ? key_q : '0;
  assign cam_addr  = (state_q == WRITE) ? free_idx : '0;

`ifdef CAM_STATS_EN
  logic [7:0] hits_q, hits_d;
  logic [7:0] misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if ((state_q == RESP) && !op_q) begin
      if (rsp_hit_q && (hits_q != 8'hFF))
        hits_d = hits_q + 8'd1;
      else if (!rsp_hit_q && (misses_q != 8'hFF))
        misses_d = misses_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign lookup_hits   = hits_q;
  assign lookup_misses = misses_q;
`endif

endmodule

// File: tb/tb_cam_client_ctrl.sv
// tb_cam_client_ctrl: directed bench for cam_client_ctrl with a behavioural 16x8 CAM (highest-index match, not reset).
// Stats checks run only when CAM_STATS_EN is defined.
module tb_cam_client_ctrl;

  logic       clock;
  logic       reset;
  logic       reqValid;
  logic       reqReady;
  logic       reqOp;
  logic [7:0] reqKey;
  logic       rspValid;
  logic       rspHit;
  logic [3:0] rspAddr;
  logic       rspErr;
  logic [4:0] count;
  logic       full;
  logic       camWen;
  logic       camRen;
  logic [7:0] camDin;
  logic [3:0] camAddr;
  logic [3:0] camDout;
  logic       camHit;
`ifdef CAM_STATS_EN
  logic [7:0] lookupHits;
  logic [7:0] lookupMisses;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int acceptCount = 0;
  int rspCount    = 0;
  int wenCount    = 0;
  int readyBusy   = 0;

  logic [7:0]  camMem [16];
  logic [15:0] camPresent = '0;
  logic        preloadEn  = 1'b0;
  logic [3:0]  preloadIdx = '0;
  logic [7:0]  preloadKey = '0;

  cam_client_ctrl dut (
    .clk(clock), .rst(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_op(reqOp), .req_key(reqKey),
    .rsp_valid(rspValid), .rsp_hit(rspHit), .rsp_addr(rspAddr), .rsp_err(rspErr),
    .count(count), .full(full),
    .cam_wen(camWen), .cam_ren(camRen), .cam_din(camDin), .cam_addr(camAddr),
    .cam_dout(camDout), .cam_hit(camHit)
`ifdef CAM_STATS_EN
    , .lookup_hits(lookupHits), .lookup_misses(lookupMisses)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural CAM: search wins over write, highest matching index reported, contents survive rst.
  always @(posedge clock) begin
    logic       h;
    logic [3:0] idx;
    if (preloadEn) begin
      camMem[preloadIdx]     <= preloadKey;
      camPresent[preloadIdx] <= 1'b1;
    end else if (camRen) begin
      h   = 1'b0;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
        if (camPresent[i] && (camMem[i] == camDin)) begin
          h   = 1'b1;
          idx = 4'(i);
        end
      end
      camHit  <= h;
      camDout <= idx;
    end else if (camWen) begin
      camMem[camAddr]     <= camDin;
      camPresent[camAddr] <= 1'b1;
    end
  end

  always @(posedge clock) begin
    if (reqValid && reqReady) acceptCount++;
    if (rspValid) rspCount++;
    if (camWen) wenCount++;
    if (reqReady && (rspValid || camRen || camWen)) readyBusy++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Issues one request from a negedge and returns at the negedge where rsp_valid is high.
  task automatic applyStimulus(input logic op, input logic [7:0] key, output int lat,
                               output logic hit, output logic [3:0] addr, output logic err);
    logic got;
    reqValid = 1'b1;
    reqOp    = op;
    reqKey   = key;
    for (int k = 0; k < 20 && !reqReady; k++) @(negedge clock);
    if (!reqReady) checkOutput("readyTimeout", 0, 1);
    @(posedge clock);
    got  = 1'b0;
    lat  = 0;
    hit  = 1'b0;
    addr = '0;
    err  = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clock);
      if (k == 1) begin
        reqValid = 1'b0;
        reqOp    = ~op;
        reqKey   = 8'hA5;
      end
      if (rspValid) begin
        got  = 1'b1;
        lat  = k;
        hit  = rspHit;
        addr = rspAddr;
        err  = rspErr;
      end
    end
    if (!got) checkOutput("rspTimeout", 0, 1);
  endtask

  initial begin
    int         lat;
    logic       hit;
    logic [3:0] addr;
    logic       err;
    int         base;
    int         rspBase;
    logic [7:0] insKeys [3];
    logic [3:0] insAddr [3];

    insKeys[0] = 8'd4;  insKeys[1] = 8'd8;  insKeys[2] = 8'd35;
    insAddr[0] = 4'd15; insAddr[1] = 4'd14; insAddr[2] = 4'd13;
    reset = 1'b1; reqValid = 1'b0; reqOp = 1'b0; reqKey = '0;
    repeat (2) @(negedge clock);
    checkOutput("rstReady", reqReady, 0);
    checkOutput("rstRspValid", rspValid, 0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstFull", full, 0);
    checkOutput("rstCamWen", camWen, 0);
    checkOutput("rstCamRen", camRen, 0);
    checkOutput("rstRsp", {rspHit, rspErr, rspAddr}, 0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("readyAfterRst", reqReady, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, insKeys[i], lat, hit, addr, err);
      checkOutput($sformatf("insAddr%0d", i), addr, insAddr[i]);
      checkOutput($sformatf("insHit%0d", i), hit, 0);
      checkOutput($sformatf("insErr%0d", i), err, 0);
      checkOutput($sformatf("insLat%0d", i), lat, 4);
    end
    checkOutput("countAfter3", count, 3);

    applyStimulus(1'b0, 8'd8, lat, hit, addr, err);
    checkOutput("look8Hit", hit, 1);
    checkOutput("look8Addr", addr, 14);
    checkOutput("look8Lat", lat, 3);
    applyStimulus(1'b0, 8'd87, lat, hit, addr, err);
    checkOutput("look87Hit", hit, 0);
    checkOutput("look87Addr", addr, 0);

    base = wenCount;
    applyStimulus(1'b1, 8'd4, lat, hit, addr, err);
    checkOutput("dupHit", hit, 1);
    checkOutput("dupAddr", addr, 15);
    checkOutput("dupLat", lat, 3);
    checkOutput("dupNoWrite", wenCount - base, 0);
    checkOutput("dupCount", count, 3);

    doReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 8'(k), lat, hit, addr, err);
      checkOutput($sformatf("fillAddr%0d", k), addr, 15 - k);
    end
    checkOutput("fillFull", full, 1);
    checkOutput("fillCount", count, 16);
    base = wenCount;
    applyStimulus(1'b1, 8'd200, lat, hit, addr, err);
    checkOutput("fullErr", err, 1);
    checkOutput("fullHit", hit, 0);
    checkOutput("fullAddr", addr, 0);
    checkOutput("fullLat", lat, 3);
    checkOutput("fullNoWrite", wenCount - base, 0);
    checkOutput("fullCountHeld", count, 16);
    applyStimulus(1'b0, 8'd0, lat, hit, addr, err);
    checkOutput("look0Hit", hit, 1);
    checkOutput("look0Addr", addr, 15);

    doReset();
    preloadEn = 1'b1; preloadIdx = 4'd3; preloadKey = 8'd77;
    @(negedge clock);
    preloadEn = 1'b0;
    applyStimulus(1'b0, 8'd77, lat, hit, addr, err);
    checkOutput("stale77Hit", hit, 0);
    checkOutput("stale77Addr", addr, 0);
    applyStimulus(1'b0, 8'd5, lat, hit, addr, err);
    checkOutput("stale5Hit", hit, 0);

    @(negedge clock);
    base    = acceptCount;
    rspBase = rspCount;
    reqValid = 1'b1; reqOp = 1'b0; reqKey = 8'd8;
    repeat (20) @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("holdAccepts", acceptCount - base, 5);
    checkOutput("holdRsps", rspCount - rspBase, 5);
    checkOutput("readyOnlyIdle", readyBusy, 0);

    doReset();
    reqValid = 1'b1; reqOp = 1'b1; reqKey = 8'd100;
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    for (int k = 0; k < 10 && !camWen; k++) @(negedge clock);
    checkOutput("wrReached", camWen, 1);
    rspBase = rspCount;
    reset = 1'b1;
    #1;
    checkOutput("abortRspValid", rspValid, 0);
    checkOutput("abortCount", count, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("abortNoRsp", rspCount - rspBase, 0);
    applyStimulus(1'b0, 8'd100, lat, hit, addr, err);
    checkOutput("abort100Miss", hit, 0);
    applyStimulus(1'b1, 8'd100, lat, hit, addr, err);
    checkOutput("reins100Addr", addr, 15);
    checkOutput("reins100Hit", hit, 0);

`ifdef CAM_STATS_EN
    doReset();
    checkOutput("statsRstHits", lookupHits, 0);
    checkOutput("statsRstMiss", lookupMisses, 0);
    applyStimulus(1'b1, 8'd1, lat, hit, addr, err);
    applyStimulus(1'b0, 8'd1, lat, hit, addr, err);
    applyStimulus(1'b0, 8'd1, lat, hit, addr, err);
    applyStimulus(1'b0, 8'd2, lat, hit, addr, err);
    @(negedge clock);
    checkOutput("statsHits", lookupHits, 2);
    checkOutput("statsMisses", lookupMisses, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
